// File: rtl/mole_hit_sensor.sv
// Per-channel switch conditioner: 2-flop sync, press/release debounce, and
// gating of press pulses against the mole electromagnet, with a saturating miss count.
module mole_hit_sensor #(
  parameter int N_MOLE     = 3,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_MOLE-1:0] sw_raw,
  input  logic [N_MOLE-1:0] mole_en,
  output logic [N_MOLE-1:0] bt_mole,
  output logic [N_MOLE-1:0] bt_level,
  output logic [7:0]        miss_cnt
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_MOLE-1:0] s1_q, s2_q;
  state_t            state_q [N_MOLE];
  state_t            state_d [N_MOLE];
  logic [CNT_W-1:0]  cnt_q   [N_MOLE];
  logic [CNT_W-1:0]  cnt_d   [N_MOLE];
  logic [N_MOLE-1:0] done_d, done_q, en_q;
  logic [N_MOLE-1:0] level_d;
  logic [N_MOLE-1:0] bt_mole_q, bt_level_q;
  logic [7:0]        miss_q;

  function automatic logic [7:0] popcount(input logic [N_MOLE-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < N_MOLE; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_comb begin
    done_d  = '0;
    level_d = '0;
    for (int i = 0; i < N_MOLE; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
      case (state_q[i])
        IDLE: begin
          if (s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Press completion and the mole_en sample are registered together, then gated one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      done_q     <= '0;
      en_q       <= '0;
      bt_mole_q  <= '0;
      bt_level_q <= '0;
      miss_q     <= '0;
      for (int i = 0; i < N_MOLE; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q       <= sw_raw;
      s2_q       <= s1_q;
      done_q     <= done_d;
      en_q       <= mole_en;
      bt_mole_q  <= done_q & ~en_q;
      bt_level_q <= level_d;
      miss_q     <= sat_add(miss_q, popcount(done_q & en_q));
      for (int i = 0; i < N_MOLE; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bt_mole  = bt_mole_q;
  assign bt_level = bt_level_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_mole_hit_sensor.sv
// Bench for mole_hit_sensor: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_mole_hit_sensor;
  localparam int N   = 3;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] mole_en = '0;
  logic [N-1:0] bt_mole, bt_level;
  logic [7:0]   miss_cnt;

  always #5 clk = ~clk;

  mole_hit_sensor #(.N_MOLE(N), .DEB_CYCLES(DEB), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .mole_en(mole_en),
    .bt_mole(bt_mole), .bt_level(bt_level), .miss_cnt(miss_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: sw_raw seen two edges late; a level flips after DEB consecutive
  // differing samples; outputs appear one edge after the flip.
  logic [N-1:0] m_d1, m_d2, lvl, pend, pend_en, m_bt, m_lvl;
  int           run [N];
  int           m_miss;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; lvl = '0; pend = '0; pend_en = '0;
      m_bt = '0; m_lvl = '0; m_miss = 0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      m_bt   = pend & ~pend_en;
      m_miss = m_miss + $countones(pend & pend_en);
      if (m_miss > 255) m_miss = 255;
      m_lvl  = lvl;
      pend   = '0;
      for (int i = 0; i < N; i++) begin
        if (m_d2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            lvl[i] = m_d2[i];
            run[i] = 0;
            if (lvl[i]) begin
              pend[i]    = 1'b1;
              pend_en[i] = mole_en[i];
            end
          end
        end else begin
          run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = sw_raw;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  int pulses [N];
  int last_pulse [N];

  initial begin
    for (int i = 0; i < N; i++) begin pulses[i] = 0; last_pulse[i] = -1; end
    forever begin
      @(posedge clk);
      #1;
      chk("model_bt_mole", 32'(bt_mole), 32'(m_bt));
      chk("model_bt_level", 32'(bt_level), 32'(m_lvl));
      chk("model_miss_cnt", 32'(miss_cnt), 32'(m_miss));
      for (int i = 0; i < N; i++)
        if (bt_mole[i] === 1'b1) begin
          pulses[i]++;
          last_pulse[i] = cyc;
        end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int r, f, pc;

  initial begin
    tick(3);
    chk("reset_bt_mole", 32'(bt_mole), 0);
    chk("reset_bt_level", 32'(bt_level), 0);
    chk("reset_miss", 32'(miss_cnt), 0);
    rst = 1'b0;

    // Basic press on channel 0: rise sampled at edge 10, pulse at edge 16
    tick(6);
    sw_raw[0] = 1'b1;
    tick(6);
    chk("t1_no_pulse_e15", 32'(bt_mole), 0);
    tick(1);
    chk("t1_pulse_e16", 32'(bt_mole), 32'b001);
    chk("t1_level_e16", 32'(bt_level), 32'b001);
    tick(1);
    chk("t1_pulse_gone_e17", 32'(bt_mole), 0);
    chk("t1_level_e17", 32'(bt_level), 32'b001);
    tick(22);
    sw_raw[0] = 1'b0;
    tick(6);
    chk("t1_level_e45", 32'(bt_level), 32'b001);
    tick(1);
    chk("t1_level_fall_e46", 32'(bt_level), 0);
    chk("t1_miss", 32'(miss_cnt), 0);
    chk("t1_pulse_count", 32'(pulses[0]), 1);

    // Glitch and bounce on channel 1
    sw_raw[1] = 1'b1;
    tick(3);
    sw_raw[1] = 1'b0;
    tick(10);
    chk("t2_glitch_pulses", 32'(pulses[1]), 0);
    chk("t2_glitch_level", 32'(bt_level[1]), 0);
    sw_raw[1] = 1'b1; tick(1);
    sw_raw[1] = 1'b0; tick(1);
    sw_raw[1] = 1'b1;
    r = cyc + 1;
    tick(12);
    chk("t2_bounce_pulses", 32'(pulses[1]), 1);
    chk("t2_bounce_edge", 32'(last_pulse[1]), 32'(r + 6));
    sw_raw[1] = 1'b0;
    tick(10);

    // Mole down on channel 2 -> miss; then mole up (en drops mid-wait) -> pulse
    mole_en[2] = 1'b1;
    sw_raw[2]  = 1'b1;
    tick(10);
    chk("t3_down_pulses", 32'(pulses[2]), 0);
    chk("t3_down_miss", 32'(miss_cnt), 1);
    sw_raw[2] = 1'b0;
    tick(10);
    sw_raw[2] = 1'b1;
    r = cyc + 1;
    tick(2);
    mole_en[2] = 1'b0;
    tick(10);
    chk("t3_up_pulses", 32'(pulses[2]), 1);
    chk("t3_up_edge", 32'(last_pulse[2]), 32'(r + 6));
    chk("t3_up_miss", 32'(miss_cnt), 1);
    sw_raw[2] = 1'b0;
    tick(10);

    // Long hold with release bounce, then press again
    sw_raw[0] = 1'b1;
    tick(50);
    sw_raw[0] = 1'b0; tick(2);
    sw_raw[0] = 1'b1; tick(2);
    sw_raw[0] = 1'b0;
    f = cyc + 1;
    tick(5);
    chk("t4_level_f4", 32'(bt_level[0]), 1);
    tick(1);
    chk("t4_level_f5", 32'(bt_level[0]), 1);
    tick(1);
    chk("t4_level_f6", 32'(bt_level[0]), 0);
    sw_raw[0] = 1'b1;
    tick(10);
    chk("t4_pulse_count", 32'(pulses[0]), 3);
    sw_raw[0] = 1'b0;
    tick(10);

    // Simultaneous presses with channel 1 held down
    mole_en = 3'b010;
    sw_raw  = 3'b111;
    tick(7);
    chk("t5_simul_pulse", 32'(bt_mole), 32'b101);
    chk("t5_simul_miss", 32'(miss_cnt), 2);
    tick(1);
    chk("t5_simul_pulse_gone", 32'(bt_mole), 0);
    sw_raw = '0;
    tick(10);

    // Saturation: 2 + 3*84 = 254, then 3-channel misses clamp at 255
    mole_en = 3'b111;
    repeat (84) begin
      sw_raw = 3'b111; tick(8);
      sw_raw = 3'b000; tick(8);
    end
    chk("t5_miss_254", 32'(miss_cnt), 254);
    sw_raw = 3'b111; tick(8);
    chk("t5_miss_sat", 32'(miss_cnt), 255);
    sw_raw = 3'b000; tick(8);
    sw_raw = 3'b111; tick(8);
    chk("t5_miss_stay_sat", 32'(miss_cnt), 255);
    sw_raw = 3'b000; tick(8);

    // Reset while channel 0 is in PRESS_WAIT with cnt=2
    mole_en = '0;
    sw_raw  = 3'b001;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_bt_mole", 32'(bt_mole), 0);
    chk("t6_rst_bt_level", 32'(bt_level), 0);
    chk("t6_rst_miss", 32'(miss_cnt), 0);
    rst = 1'b0;
    pc = pulses[0];
    tick(6);
    chk("t6_no_pulse_p5", 32'(bt_mole), 0);
    tick(1);
    chk("t6_pulse_p6", 32'(bt_mole), 32'b001);
    tick(3);
    chk("t6_pulse_count", 32'(pulses[0]), 32'(pc + 1));
    sw_raw = '0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
